// File: rtl/isqrt_pkg.sv
// isqrt_pkg: shared state encoding and width helpers for the sequential square root.
// Revision 1.0
`default_nettype none

package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int rad_w(input int n);
        return 2 * n;
    endfunction

    function automatic int rem_w(input int n);
        return n + 1;
    endfunction

    function automatic int acc_w(input int n);
        return n + 2;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_step.sv
// isqrt_step: one combinational restoring square-root iteration (one root bit).
// Revision 1.0
`default_nettype none

module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [acc_w(N)-1:0] rem_acc_i,
    input  logic [N-1:0]        root_acc_i,
    input  logic [1:0]          top2_i,
    output logic [acc_w(N)-1:0] rem_acc_nx_o,
    output logic [N-1:0]        root_acc_nx_o
);

    localparam int ACC_W = acc_w(N);

    // Shift kept two bits wider so the compare sees every input bit; the
    // remainder bound (<= 2*root) guarantees the kept result fits ACC_W.
    logic [ACC_W+1:0] w_shift;
    logic [ACC_W+1:0] w_trial;
    logic             w_ge;

    assign w_shift = {rem_acc_i, top2_i};
    assign w_trial = {2'b00, root_acc_i, 2'b01};
    assign w_ge    = (w_shift >= w_trial);

    assign rem_acc_nx_o  = w_ge ? ACC_W'(w_shift - w_trial) : w_shift[ACC_W-1:0];
    assign root_acc_nx_o = {root_acc_i[N-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/isqrt_seq.sv
// isqrt_seq: valid/ready sequential integer square root, one root bit per clock.
// Revision 1.0
`default_nettype none

module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*N-1:0]      in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_root,
    output logic [N:0]          out_rem,
    output logic                out_exact
);

    localparam int RAD_W = rad_w(N);
    localparam int REM_W = rem_w(N);
    localparam int ACC_W = acc_w(N);
    localparam int CNT_W = cnt_w(N);

    state_t             state_q, state_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [ACC_W-1:0]   rem_q, rem_d;
    logic [N-1:0]       root_q, root_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       out_root_q, out_root_d;
    logic [REM_W-1:0]   out_rem_q, out_rem_d;
    logic               out_exact_q, out_exact_d;

    logic [ACC_W-1:0]   w_rem_nx;
    logic [N-1:0]       w_root_nx;
    logic               w_accept;
    logic               w_last;

    isqrt_step #(.N(N)) u_step (
        .rem_acc_i     (rem_q),
        .root_acc_i    (root_q),
        .top2_i        (rad_q[RAD_W-1 -: 2]),
        .rem_acc_nx_o  (w_rem_nx),
        .root_acc_nx_o (w_root_nx)
    );

    assign w_accept = in_valid && (state_q == IDLE);
    assign w_last   = (state_q == CALC) && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (w_last)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        out_root_d  = out_root_q;
        out_rem_d   = out_rem_q;
        out_exact_d = out_exact_q;
        if (w_accept) begin
            rad_d  = in_data;
            rem_d  = '0;
            root_d = '0;
            cnt_d  = CNT_W'(N - 1);
        end else if (state_q == CALC) begin
            rad_d  = {rad_q[RAD_W-3:0], 2'b00};
            rem_d  = w_rem_nx;
            root_d = w_root_nx;
            cnt_d  = cnt_q - 1'b1;
            // Results land in the output registers on the final iteration edge.
            if (w_last) begin
                out_root_d  = w_root_nx;
                out_rem_d   = w_rem_nx[REM_W-1:0];
                out_exact_d = (w_rem_nx == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            out_root_q  <= '0;
            out_rem_q   <= '0;
            out_exact_q <= 1'b0;
        end else begin
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            out_root_q  <= out_root_d;
            out_rem_q   <= out_rem_d;
            out_exact_q <= out_exact_d;
        end
    end

    assign out_root  = out_root_q;
    assign out_rem   = out_rem_q;
    assign out_exact = out_exact_q;

endmodule

`default_nettype wire

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: directed and randomised checks of isqrt_seq with N=4.
// Revision 1.0
`default_nettype none

module tb_isqrt_seq;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_root;
    logic [N:0]     out_rem;
    logic           out_exact;

    int n_cmp;
    int n_err;

    isqrt_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .out_exact (out_exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a radicand and return at the negedge after the accepting edge.
    task automatic send(input logic [2*N-1:0] d);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("accept_timeout", int'(ok), 1);
    endtask

    // Wait for out_valid; latency counts edges since the acceptance negedge.
    task automatic get_result(output int root, output int rem, output int exact, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("valid_timeout", int'(out_valid), 1);
        root  = int'(out_root);
        rem   = int'(out_rem);
        exact = int'(out_exact);
        if (out_ready) @(negedge clk);
    endtask

    int r, m, e, lat;
    int x, seen;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  int'(in_ready),  1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_root",      int'(out_root),  0);
        chk("rst_rem",       int'(out_rem),   0);
        chk("rst_exact",     int'(out_exact), 0);
        rst = 1'b0;
        @(negedge clk);

        send(8'd225);
        get_result(r, m, e, lat);
        chk("225_latency", lat, 4);
        chk("225_root", r, 15);
        chk("225_rem", m, 0);
        chk("225_exact", e, 1);
        chk("225_idle_after", int'(in_ready), 1);

        send(8'd224);
        get_result(r, m, e, lat);
        chk("224_root", r, 14);
        chk("224_rem", m, 28);
        chk("224_exact", e, 0);

        send(8'd255);
        get_result(r, m, e, lat);
        chk("255_root", r, 15);
        chk("255_rem", m, 30);
        chk("255_exact", e, 0);

        send(8'd0);
        get_result(r, m, e, lat);
        chk("0_root", r, 0);
        chk("0_rem", m, 0);
        chk("0_exact", e, 1);

        // Backpressure with a competing radicand held upstream.
        out_ready = 1'b0;
        send(8'd100);
        get_result(r, m, e, lat);
        in_valid = 1'b1;
        in_data  = 8'd50;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_root", int'(out_root), 10);
            chk("bp_rem", int'(out_rem), 0);
            chk("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_one_handshake", int'(out_valid), 0);
        chk("bp_no_bypass", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accepted", int'(in_ready), 0);
        get_result(r, m, e, lat);
        chk("50_root", r, 7);
        chk("50_rem", m, 1);
        chk("50_exact", e, 0);

        // Reset two cycles into a calculation.
        send(8'd200);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_root", int'(out_root), 0);
        chk("mid_rst_rem", int'(out_rem), 0);
        chk("mid_rst_exact", int'(out_exact), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 0);

        // Closed loop: perfect squares must come back exact.
        for (int k = 0; k < 16; k++) begin
            send(8'(k * k));
            get_result(r, m, e, lat);
            chk("loop_root", r, k);
            chk("loop_rem", m, 0);
            chk("loop_exact", e, 1);
        end

        // Random radicands with random consumer stalls.
        for (int k = 0; k < 200; k++) begin
            x = int'($urandom_range(0, 255));
            send(8'(x));
            seen = 0;
            for (int c = 0; c < 60; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("rnd_handshake", seen, 1);
            r = int'(out_root);
            m = int'(out_rem);
            @(negedge clk);
            chk("rnd_root_lo", int'(r * r <= x), 1);
            chk("rnd_root_hi", int'(x < (r + 1) * (r + 1)), 1);
            chk("rnd_rem", m, x - r * r);
        end
        out_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
